// File: rtl/bp_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | bp_pkg : shared types and counter helpers for the PHT controller   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package bp_pkg;

   localparam int BP_K = 4;
   localparam int BP_N = 2;

   typedef enum logic [0:0] {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } bp_state_t;

   typedef struct packed {
      logic [BP_K-1:0] idx;
      logic [BP_N-1:0] ctr;
      logic            pred;
   } bp_entry_t;

   // Weakly not-taken: 0111..1
   function automatic logic [BP_N-1:0] bp_ctr_init();
      return {1'b0, {(BP_N-1){1'b1}}};
   endfunction

   function automatic logic [BP_N-1:0] bp_ctr_update(input logic [BP_N-1:0] ctr,
                                                     input logic            taken);
      if (taken)
         return (&ctr) ? ctr : ctr + BP_N'(1);
      else
         return (|ctr) ? ctr - BP_N'(1) : ctr;
   endfunction

endpackage
`default_nettype wire

// File: rtl/bp_inflight_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | bp_inflight_fifo : in-order in-flight branch queue with flush and  |
// | per-entry index-match counter patching.   Rev 1.0                  |
// +--------------------------------------------------------------------+
module bp_inflight_fifo
   import bp_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int K     = BP_K,
   parameter int N     = BP_N
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         i_push,
   input  logic [K-1:0] i_push_idx,
   input  logic [N-1:0] i_push_ctr,
   input  logic         i_push_pred,
   input  logic         i_pop,
   input  logic         i_flush,
   input  logic         i_patch_en,
   input  logic [K-1:0] i_patch_idx,
   input  logic [N-1:0] i_patch_ctr,
   output logic [K-1:0] o_head_idx,
   output logic [N-1:0] o_head_ctr,
   output logic         o_head_pred,
   output logic         o_empty,
   output logic         o_full
);

   localparam int AW = $clog2(DEPTH);

   bp_entry_t       r_mem [DEPTH];
   logic [AW:0]     r_rd_ptr;
   logic [AW:0]     r_wr_ptr;
   logic [AW-1:0]   w_rd_addr;
   logic [AW-1:0]   w_wr_addr;
   bp_entry_t       w_push_entry;

   assign w_rd_addr = r_rd_ptr[AW-1:0];
   assign w_wr_addr = r_wr_ptr[AW-1:0];
   assign o_empty   = (r_rd_ptr == r_wr_ptr);
   assign o_full    = (r_rd_ptr[AW] != r_wr_ptr[AW]) && (w_rd_addr == w_wr_addr);

   assign o_head_idx  = r_mem[w_rd_addr].idx;
   assign o_head_ctr  = r_mem[w_rd_addr].ctr;
   assign o_head_pred = r_mem[w_rd_addr].pred;

   // An entry pushed in the same cycle as a matching resolve must see the new count
   always_comb begin
      w_push_entry.idx  = i_push_idx;
      w_push_entry.pred = i_push_pred;
      w_push_entry.ctr  = (i_patch_en && (i_patch_idx == i_push_idx)) ? i_patch_ctr : i_push_ctr;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
      end else if (i_flush) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
      end else begin
         if (i_pop)
            r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
         if (i_push)
            r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++)
            r_mem[i] <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (i_push && (w_wr_addr == AW'(i)))
               r_mem[i] <= w_push_entry;
            else if (i_patch_en && (r_mem[i].idx == i_patch_idx))
               r_mem[i].ctr <= i_patch_ctr;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/bp_pht_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | bp_pht_ctrl : PHT sequencer (history, index, predict/resolve, init |
// | sweep). Macro BP_GSHARE_HASH_EN selects pc^history indexing. Rev1.0|
// +--------------------------------------------------------------------+
module bp_pht_ctrl
   import bp_pkg::*;
#(
   parameter int K     = BP_K,
   parameter int N     = BP_N,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         pred_req_valid,
   input  logic [K-1:0] pred_req_pc,
   output logic         pred_req_ready,
   output logic         pred_taken,
   input  logic         resolve_valid,
   input  logic         resolve_taken,
   output logic         mispredict,
   output logic [K-1:0] pht_rd_idx,
   input  logic [N-1:0] pht_rd_data,
   output logic         pht_wr_en,
   output logic [K-1:0] pht_wr_idx,
   output logic [N-1:0] pht_wr_data,
   output logic         busy,
   output logic         err_underflow
);

   bp_state_t    r_state;
   logic [K:0]   r_init_cnt;
   logic [K-1:0] r_bhr_spec;
   logic [K-1:0] r_bhr_commit;
   logic         r_wr_en;
   logic [K-1:0] r_wr_idx;
   logic [N-1:0] r_wr_data;
   logic         r_mispredict;
   logic         r_err;

   logic [K-1:0] w_idx;
   logic [N-1:0] w_ctr_eff;
   logic         w_pred;
   logic         w_accept;
   logic         w_resolve;
   logic         w_mis;
   logic [N-1:0] w_new_ctr;
   logic [K-1:0] w_commit_next;
   logic [K-1:0] w_head_idx;
   logic [N-1:0] w_head_ctr;
   logic         w_head_pred;
   logic         w_empty;
   logic         w_full;

`ifdef BP_GSHARE_HASH_EN
   assign w_idx = pred_req_pc ^ r_bhr_spec;
`else
   logic w_unused_pc;
   assign w_unused_pc = ^pred_req_pc;
   assign w_idx       = r_bhr_spec;
`endif

   // Bypass the write still in flight to the table
   assign w_ctr_eff = (r_wr_en && (r_wr_idx == w_idx)) ? r_wr_data : pht_rd_data;
   assign w_pred    = w_ctr_eff[N-1];

   assign busy           = (r_state == ST_INIT);
   assign pred_req_ready = !busy && !w_full;
   assign pred_taken     = w_pred;
   assign pht_rd_idx     = w_idx;
   assign pht_wr_en      = r_wr_en;
   assign pht_wr_idx     = r_wr_idx;
   assign pht_wr_data    = r_wr_data;
   assign mispredict     = r_mispredict;
   assign err_underflow  = r_err;

   assign w_accept      = pred_req_valid && pred_req_ready;
   assign w_resolve     = resolve_valid && (r_state == ST_RUN) && !w_empty;
   assign w_mis         = w_resolve && (resolve_taken != w_head_pred);
   assign w_new_ctr     = bp_ctr_update(w_head_ctr, resolve_taken);
   assign w_commit_next = {r_bhr_commit[K-2:0], resolve_taken};

   bp_inflight_fifo #(
      .DEPTH (DEPTH),
      .K     (K),
      .N     (N)
   ) u_fifo (
      .clk         (clk),
      .reset_n     (reset_n),
      .i_push      (w_accept && !w_mis),
      .i_push_idx  (w_idx),
      .i_push_ctr  (w_ctr_eff),
      .i_push_pred (w_pred),
      .i_pop       (w_resolve && !w_mis),
      .i_flush     (w_mis),
      .i_patch_en  (w_resolve),
      .i_patch_idx (w_head_idx),
      .i_patch_ctr (w_new_ctr),
      .o_head_idx  (w_head_idx),
      .o_head_ctr  (w_head_ctr),
      .o_head_pred (w_head_pred),
      .o_empty     (w_empty),
      .o_full      (w_full)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= ST_INIT;
         r_init_cnt   <= '0;
         r_bhr_spec   <= '0;
         r_bhr_commit <= '0;
         r_wr_en      <= 1'b0;
         r_wr_idx     <= '0;
         r_wr_data    <= '0;
         r_mispredict <= 1'b0;
         r_err        <= 1'b0;
      end else begin
         r_mispredict <= w_mis;
         if (resolve_valid && !w_resolve)
            r_err <= 1'b1;
         case (r_state)
            ST_INIT: begin
               // One extra cycle after the last write keeps busy high until it has issued
               if (!r_init_cnt[K]) begin
                  r_wr_en    <= 1'b1;
                  r_wr_idx   <= r_init_cnt[K-1:0];
                  r_wr_data  <= bp_ctr_init();
                  r_init_cnt <= r_init_cnt + (K+1)'(1);
               end else begin
                  r_wr_en <= 1'b0;
                  r_state <= ST_RUN;
               end
            end
            default: begin
               r_wr_en <= w_resolve;
               if (w_resolve) begin
                  r_wr_idx     <= w_head_idx;
                  r_wr_data    <= w_new_ctr;
                  r_bhr_commit <= w_commit_next;
               end
               if (w_mis)
                  r_bhr_spec <= w_commit_next;
               else if (w_accept)
                  r_bhr_spec <= {r_bhr_spec[K-2:0], w_pred};
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_bp_pht_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_bp_pht_ctrl : scoreboard bench for bp_pht_ctrl with a behavioural|
// | table/queue model.  Rev 1.0                                        |
// +--------------------------------------------------------------------+
module tb_bp_pht_ctrl;

   localparam int K     = 4;
   localparam int N     = 2;
   localparam int DEPTH = 4;
   localparam int TBL   = 1 << K;
   localparam logic [N-1:0] CMAX  = '1;
   localparam logic [N-1:0] CONE  = N'(1);
   localparam logic [N-1:0] CINIT = N'((1 << (N-1)) - 1);

   logic         clk = 1'b0;
   logic         reset_n;
   logic         pred_req_valid;
   logic [K-1:0] pred_req_pc;
   logic         pred_req_ready;
   logic         pred_taken;
   logic         resolve_valid;
   logic         resolve_taken;
   logic         mispredict;
   logic [K-1:0] pht_rd_idx;
   logic [N-1:0] pht_rd_data;
   logic         pht_wr_en;
   logic [K-1:0] pht_wr_idx;
   logic [N-1:0] pht_wr_data;
   logic         busy;
   logic         err_underflow;

   always #5 clk = ~clk;

   bp_pht_ctrl #(.K(K), .N(N), .DEPTH(DEPTH)) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .pred_req_valid (pred_req_valid),
      .pred_req_pc    (pred_req_pc),
      .pred_req_ready (pred_req_ready),
      .pred_taken     (pred_taken),
      .resolve_valid  (resolve_valid),
      .resolve_taken  (resolve_taken),
      .mispredict     (mispredict),
      .pht_rd_idx     (pht_rd_idx),
      .pht_rd_data    (pht_rd_data),
      .pht_wr_en      (pht_wr_en),
      .pht_wr_idx     (pht_wr_idx),
      .pht_wr_data    (pht_wr_data),
      .busy           (busy),
      .err_underflow  (err_underflow)
   );

   // Counter table: combinational read, synchronous write
   logic [N-1:0] tbl [TBL];
   initial for (int i = 0; i < TBL; i++) tbl[i] = '0;
   always @(posedge clk) if (pht_wr_en) tbl[pht_wr_idx] <= pht_wr_data;
   assign pht_rd_data = tbl[pht_rd_idx];

   typedef struct {
      logic [K-1:0] idx;
      logic [N-1:0] ctr;
      logic         pred;
   } ent_t;
   typedef struct {
      logic [K-1:0] idx;
      logic [N-1:0] data;
   } wr_t;

   ent_t         m_q [$];
   wr_t          exp_wr [$];
   wr_t          mon_e;
   logic [N-1:0] m_tbl [TBL];
   logic [K-1:0] m_bspec;
   logic [K-1:0] m_bcommit;
   bit           m_err;
   int           m_edge;
   int           n_tests = 0;
   int           n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Scoreboard consumer: every table write must match the oldest expectation
   always @(negedge clk) begin
      if (reset_n && pht_wr_en) begin
         check("wr_expected", 32'(exp_wr.size() != 0), 32'(1));
         if (exp_wr.size() != 0) begin
            mon_e = exp_wr.pop_front();
            check("wr_idx", 32'(pht_wr_idx), 32'(mon_e.idx));
            check("wr_data", 32'(pht_wr_data), 32'(mon_e.data));
         end
      end
   end

   task automatic do_reset();
      wr_t w;
      reset_n        = 1'b0;
      pred_req_valid = 1'b0;
      pred_req_pc    = '0;
      resolve_valid  = 1'b0;
      resolve_taken  = 1'b0;
      exp_wr.delete();
      m_q.delete();
      m_bspec   = '0;
      m_bcommit = '0;
      m_err     = 1'b0;
      m_edge    = 0;
      #1;
      check("rst_busy", 32'(busy), 32'(1));
      check("rst_ready", 32'(pred_req_ready), 32'(0));
      check("rst_wr_en", 32'(pht_wr_en), 32'(0));
      check("rst_wr_idx", 32'(pht_wr_idx), 32'(0));
      check("rst_wr_data", 32'(pht_wr_data), 32'(0));
      check("rst_mispredict", 32'(mispredict), 32'(0));
      check("rst_err", 32'(err_underflow), 32'(0));
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < TBL; i++) begin
         w.idx  = K'(i);
         w.data = CINIT;
         exp_wr.push_back(w);
         m_tbl[i] = CINIT;
      end
   endtask

   // One cycle, entered just after a falling edge
   task automatic step(input bit pv, input logic [K-1:0] pc, input bit rv, input bit rt);
      logic [K-1:0] idx;
      logic [N-1:0] ctr;
      logic [N-1:0] nc;
      bit           rdy, acc, res, mis;
      ent_t         h, e;
      wr_t          w;
      pred_req_valid = pv;
      pred_req_pc    = pc;
      resolve_valid  = rv;
      resolve_taken  = rt;
      #1;
`ifdef BP_GSHARE_HASH_EN
      idx = pc ^ m_bspec;
`else
      idx = m_bspec;
`endif
      ctr = m_tbl[idx];
      rdy = (m_edge >= TBL + 1) && (m_q.size() < DEPTH);
      check("busy", 32'(busy), 32'(m_edge < TBL + 1));
      check("ready", 32'(pred_req_ready), 32'(rdy));
      acc = pv && rdy;
      if (acc) begin
         check("rd_idx", 32'(pht_rd_idx), 32'(idx));
         check("pred_taken", 32'(pred_taken), 32'(ctr[N-1]));
      end
      res = rv && (m_edge >= TBL + 1) && (m_q.size() != 0);
      mis = 1'b0;
      nc  = '0;
      if (rv && !res) m_err = 1'b1;
      if (res) begin
         h  = m_q.pop_front();
         nc = rt ? ((h.ctr == CMAX) ? h.ctr : h.ctr + CONE)
                 : ((h.ctr == '0)   ? h.ctr : h.ctr - CONE);
         w.idx  = h.idx;
         w.data = nc;
         exp_wr.push_back(w);
         m_tbl[h.idx] = nc;
         foreach (m_q[i]) if (m_q[i].idx == h.idx) m_q[i].ctr = nc;
         m_bcommit = {m_bcommit[K-2:0], rt};
         mis = (rt != h.pred);
      end
      if (mis) begin
         m_q.delete();
         m_bspec = m_bcommit;
      end else if (acc) begin
         e.idx  = idx;
         e.ctr  = (res && (idx == h.idx)) ? nc : ctr;
         e.pred = ctr[N-1];
         m_q.push_back(e);
         m_bspec = {m_bspec[K-2:0], ctr[N-1]};
      end
      @(posedge clk);
      #1;
      m_edge++;
      check("mispredict", 32'(mispredict), 32'(mis));
      check("err_underflow", 32'(err_underflow), 32'(m_err));
      @(negedge clk);
   endtask

   initial begin
      do_reset();
      repeat (TBL + 1) step(1'b0, '0, 1'b0, 1'b0);

      // Not-taken pair at one index: decrement then saturate at 0
      step(1'b1, 4'd3, 1'b0, 1'b0);
      step(1'b0, '0,   1'b1, 1'b0);
      step(1'b1, 4'd3, 1'b0, 1'b0);
      step(1'b0, '0,   1'b1, 1'b0);
      // Taken resolves: mispredicts, increments, recovery of history
      repeat (4) begin
         step(1'b1, 4'd3, 1'b0, 1'b0);
         step(1'b1, 4'd3, 1'b1, 1'b1);
         step(1'b0, '0,   1'b1, 1'b1);
      end
      // Three in flight, resolve with patching, then a mispredict flush
      repeat (3) step(1'b1, 4'd5, 1'b0, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0);
      step(1'b1, 4'd5, 1'b1, 1'b1);
      step(1'b0, '0, 1'b1, 1'b0);
      // Fill the FIFO, resolve while full, then drain and underflow
      repeat (5) step(1'b1, 4'd9, 1'b0, 1'b0);
      step(1'b1, 4'd9, 1'b1, 1'b0);
      repeat (5) step(1'b0, '0, 1'b1, 1'b0);

      // Random traffic with phase-biased outcomes
      for (int c = 0; c < 400; c++) begin
         step(1'(($urandom_range(0, 3) != 0)), K'($urandom_range(0, TBL - 1)),
              1'($urandom_range(0, 1)),
              1'(($urandom_range(0, 3) != 0) ^ ((c / 50) % 2 == 1)));
      end

      // Asynchronous reset in the middle of a cycle, then resolve while busy
      #3;
      do_reset();
      step(1'b1, 4'd1, 1'b1, 1'b1);
      repeat (TBL) step(1'b0, '0, 1'b0, 1'b0);
      for (int c = 0; c < 60; c++) begin
         step(1'(($urandom_range(0, 1))), K'($urandom_range(0, TBL - 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      repeat (3) step(1'b0, '0, 1'b0, 1'b0);
      check("wr_drained", 32'(exp_wr.size()), 32'(0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
